// File: rtl/sys_bus_pkg.sv
// sys_bus_pkg: shared helpers for the sys_bus interconnect.
//   idx_width(n) - bit width needed to index n ports, never less than 1 bit.
`timescale 1ns/1ps
package sys_bus_pkg;

  // A single port still needs a 1-bit index so that index vectors stay legal.
  function automatic int unsigned idx_width(input int unsigned n);
    if (n > 32'd1) begin
      return $clog2(n);
    end else begin
      return 32'd1;
    end
  endfunction

endpackage

// File: rtl/sys_bus_addr_dec.sv
// sys_bus_addr_dec: mask/base address decoder.
//   addr                  in  byte address of the winning host
//   cfg_device_addr_base  in  per-device base address
//   cfg_device_addr_mask  in  per-device address mask
//   hit                   out some device matches addr
//   dev_idx               out index of the lowest-numbered matching device
`timescale 1ns/1ps
module sys_bus_addr_dec
  import sys_bus_pkg::*;
#(
  parameter int unsigned NrDevices    = 1,
  parameter int unsigned AddressWidth = 32,
  localparam int unsigned DevIdxW     = idx_width(NrDevices)
) (
  input  logic [AddressWidth-1:0] addr,
  input  logic [AddressWidth-1:0] cfg_device_addr_base [NrDevices],
  input  logic [AddressWidth-1:0] cfg_device_addr_mask [NrDevices],
  output logic                    hit,
  output logic [DevIdxW-1:0]      dev_idx
);

  // Priority decode: the first matching device claims the access.
  always_comb begin
    hit     = 1'b0;
    dev_idx = '0;
    for (int d = 0; d < int'(NrDevices); d++) begin
      if (!hit && ((addr & cfg_device_addr_mask[d]) == cfg_device_addr_base[d])) begin
        hit     = 1'b1;
        dev_idx = DevIdxW'(d);
      end else begin
        hit = hit;
      end
    end
  end

endmodule

// File: rtl/sys_bus.sv
// sys_bus: single-level memory-mapped interconnect, NrHosts masters to NrDevices slaves.
//   clk_i, rst_i                       clock, asynchronous active-high reset
//   host_req/addr/we/be/wdata_i        host requests
//   host_gnt_o                         combinational grant to the fixed-priority winner
//   host_rvalid/rdata/err_o            response, one cycle after grant
//   device_req_o                       request to the decoded device only
//   device_addr/we/be/wdata_o          winner's request, broadcast to all devices
//   device_rvalid/rdata/err_i          device responses
//   cfg_device_addr_base/mask          address map
// Unmapped accesses are granted and answered next cycle with err=1, rdata=0.
`timescale 1ns/1ps
module sys_bus
  import sys_bus_pkg::*;
#(
  parameter int unsigned NrDevices    = 1,
  parameter int unsigned NrHosts      = 1,
  parameter int unsigned DataWidth    = 32,
  parameter int unsigned AddressWidth = 32
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic [NrHosts-1:0]        host_req_i,
  output logic [NrHosts-1:0]        host_gnt_o,
  input  logic [AddressWidth-1:0]   host_addr_i   [NrHosts],
  input  logic [NrHosts-1:0]        host_we_i,
  input  logic [DataWidth/8-1:0]    host_be_i     [NrHosts],
  input  logic [DataWidth-1:0]      host_wdata_i  [NrHosts],
  output logic [NrHosts-1:0]        host_rvalid_o,
  output logic [DataWidth-1:0]      host_rdata_o  [NrHosts],
  output logic [NrHosts-1:0]        host_err_o,
  output logic [NrDevices-1:0]      device_req_o,
  output logic [AddressWidth-1:0]   device_addr_o  [NrDevices],
  output logic [NrDevices-1:0]      device_we_o,
  output logic [DataWidth/8-1:0]    device_be_o    [NrDevices],
  output logic [DataWidth-1:0]      device_wdata_o [NrDevices],
  input  logic [NrDevices-1:0]      device_rvalid_i,
  input  logic [DataWidth-1:0]      device_rdata_i [NrDevices],
  input  logic [NrDevices-1:0]      device_err_i,
  input  logic [AddressWidth-1:0]   cfg_device_addr_base [NrDevices],
  input  logic [AddressWidth-1:0]   cfg_device_addr_mask [NrDevices]
);

  localparam int unsigned HostIdxW = idx_width(NrHosts);
  localparam int unsigned DevIdxW  = idx_width(NrDevices);

  logic [HostIdxW-1:0]  win_s;
  logic                 any_req_s;
  logic                 dev_hit_s;
  logic [DevIdxW-1:0]   dev_idx_s;
  logic [HostIdxW-1:0]  host_sel_r;
  logic [DevIdxW-1:0]   dev_sel_r;
  logic                 unmapped_r;
  logic                 pend_r;
  logic                 rsp_valid_s;
  logic                 rsp_err_s;
  logic [DataWidth-1:0] rsp_data_s;

  // Fixed-priority arbitration: lowest-index requesting host wins.
  always_comb begin
    win_s     = '0;
    any_req_s = 1'b0;
    for (int h = 0; h < int'(NrHosts); h++) begin
      if (host_req_i[h] && !any_req_s) begin
        any_req_s = 1'b1;
        win_s     = HostIdxW'(h);
      end else begin
        any_req_s = any_req_s;
      end
    end
  end

  sys_bus_addr_dec #(
    .NrDevices    (NrDevices),
    .AddressWidth (AddressWidth)
  ) u_addr_dec (
    .addr                 (host_addr_i[win_s]),
    .cfg_device_addr_base (cfg_device_addr_base),
    .cfg_device_addr_mask (cfg_device_addr_mask),
    .hit                  (dev_hit_s),
    .dev_idx              (dev_idx_s)
  );

  // Grant and device request; both forced low while reset is held.
  always_comb begin
    host_gnt_o   = '0;
    device_req_o = '0;
    if (any_req_s && !rst_i) begin
      host_gnt_o[win_s] = 1'b1;
      if (dev_hit_s) begin
        device_req_o[dev_idx_s] = 1'b1;
      end else begin
        device_req_o = '0;
      end
    end else begin
      host_gnt_o = '0;
    end
  end

  // Winner's request is broadcast; devices qualify it with their own req.
  always_comb begin
    for (int d = 0; d < int'(NrDevices); d++) begin
      device_addr_o[d]  = host_addr_i[win_s];
      device_we_o[d]    = host_we_i[win_s];
      device_be_o[d]    = host_be_i[win_s];
      device_wdata_o[d] = host_wdata_i[win_s];
    end
  end

  // Capture winner/decode of each granted cycle; pend_r marks the one
  // outstanding response so that a transaction cut by reset is never answered.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      host_sel_r <= '0;
      dev_sel_r  <= '0;
      unmapped_r <= 1'b0;
      pend_r     <= 1'b0;
    end else if (any_req_s) begin
      host_sel_r <= win_s;
      dev_sel_r  <= dev_idx_s;
      unmapped_r <= ~dev_hit_s;
      pend_r     <= 1'b1;
    end else begin
      unmapped_r <= 1'b0;
      pend_r     <= 1'b0;
    end
  end

  // Select the response source: error for unmapped, else the addressed device.
  always_comb begin
    rsp_valid_s = 1'b0;
    rsp_err_s   = 1'b0;
    rsp_data_s  = '0;
    if (!pend_r) begin
      rsp_valid_s = 1'b0;
    end else if (unmapped_r) begin
      rsp_valid_s = 1'b1;
      rsp_err_s   = 1'b1;
    end else if (device_rvalid_i[dev_sel_r]) begin
      rsp_valid_s = 1'b1;
      rsp_err_s   = device_err_i[dev_sel_r];
      rsp_data_s  = device_rdata_i[dev_sel_r];
    end else begin
      rsp_valid_s = 1'b0;
    end
  end

  // Route the response to the captured host; everyone else sees zeros.
  always_comb begin
    host_rvalid_o = '0;
    host_err_o    = '0;
    for (int h = 0; h < int'(NrHosts); h++) begin
      host_rdata_o[h] = '0;
    end
    if (rsp_valid_s) begin
      host_rvalid_o[host_sel_r] = 1'b1;
      host_err_o[host_sel_r]    = rsp_err_s;
      host_rdata_o[host_sel_r]  = rsp_data_s;
    end else begin
      host_rvalid_o = '0;
    end
  end

endmodule

// File: tb/tb_sys_bus.sv
// tb_sys_bus: directed stimulus with a response scoreboard for sys_bus
// (2 hosts, 3 devices). Grants and device requests are checked as they are
// issued; expected responses are queued and popped by a monitor on rvalid.
`timescale 1ns/1ps
module tb_sys_bus;
  localparam int NH = 2;
  localparam int ND = 3;
  localparam int DW = 32;
  localparam int AW = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic [NH-1:0] host_req, host_gnt, host_we, host_rvalid, host_err;
  logic [AW-1:0] host_addr  [NH];
  logic [3:0]    host_be    [NH];
  logic [DW-1:0] host_wdata [NH];
  logic [DW-1:0] host_rdata [NH];
  logic [ND-1:0] device_req, device_we;
  logic [ND-1:0] device_rvalid = '0;
  logic [ND-1:0] device_err    = '0;
  logic [AW-1:0] device_addr  [ND];
  logic [3:0]    device_be    [ND];
  logic [DW-1:0] device_wdata [ND];
  logic [DW-1:0] device_rdata [ND] = '{default: '0};
  logic [AW-1:0] cfg_base [ND];
  logic [AW-1:0] cfg_mask [ND];
  logic          timer_err;

  int n_total = 0;
  int n_pass  = 0;

  typedef struct {
    int          host;
    logic [31:0] rdata;
    logic        err;
  } exp_t;
  exp_t sb_q[$];

  always #5 clk = ~clk;

  sys_bus #(.NrDevices(ND), .NrHosts(NH), .DataWidth(DW), .AddressWidth(AW)) dut (
    .clk_i(clk), .rst_i(rst),
    .host_req_i(host_req), .host_gnt_o(host_gnt), .host_addr_i(host_addr),
    .host_we_i(host_we), .host_be_i(host_be), .host_wdata_i(host_wdata),
    .host_rvalid_o(host_rvalid), .host_rdata_o(host_rdata), .host_err_o(host_err),
    .device_req_o(device_req), .device_addr_o(device_addr), .device_we_o(device_we),
    .device_be_o(device_be), .device_wdata_o(device_wdata),
    .device_rvalid_i(device_rvalid), .device_rdata_i(device_rdata), .device_err_i(device_err),
    .cfg_device_addr_base(cfg_base), .cfg_device_addr_mask(cfg_mask)
  );

  // Device model: answers one cycle after its req; dev2 (timer) errors on demand.
  always @(posedge clk) begin
    device_rvalid   <= device_req;
    device_err      <= {timer_err & device_req[2], 2'b00};
    device_rdata[0] <= device_req[0] ? 32'hDEAD_BEEF : 32'h0;
    device_rdata[1] <= device_req[1] ? 32'h0000_1111 : 32'h0;
    device_rdata[2] <= device_req[2] ? 32'h2222_0000 : 32'h0;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) begin
      $display("FAIL %s: got 0x%08h, required 0x%08h", name, act, exp);
    end else begin
      n_pass++;
    end
  endtask

  task automatic push_exp(input int h, input logic [31:0] d, input logic e);
    exp_t x;
    x.host  = h;
    x.rdata = d;
    x.err   = e;
    sb_q.push_back(x);
  endtask

  task automatic set_host(input int h, input logic req, input logic [31:0] addr,
                          input logic we, input logic [31:0] wdata);
    host_req[h]   = req;
    host_addr[h]  = addr;
    host_we[h]    = we;
    host_be[h]    = 4'hF;
    host_wdata[h] = wdata;
  endtask

  // Step to just after the next rising edge.
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // Monitor: every rvalid must match the oldest queued expectation.
  always @(negedge clk) begin
    if (rst === 1'b0) begin
      for (int h = 0; h < NH; h++) begin
        if (host_rvalid[h] === 1'b1) begin
          exp_t e;
          if (sb_q.size() == 0) begin
            n_total++;
            $display("FAIL unexpected_rvalid: host%0d got rvalid=1, required no response", h);
          end else begin
            e = sb_q.pop_front();
            chk("rsp_host", h, e.host);
            chk("rsp_rdata", host_rdata[h], e.rdata);
            chk("rsp_err", {31'd0, host_err[h]}, {31'd0, e.err});
          end
        end
      end
    end
  end

  initial begin
    cfg_base[0] = 32'h0010_0000; cfg_mask[0] = ~32'h000F_FFFF;
    cfg_base[1] = 32'h0002_0000; cfg_mask[1] = ~32'h0000_03FF;
    cfg_base[2] = 32'h0003_0000; cfg_mask[2] = ~32'h0000_03FF;
    timer_err = 1'b0;
    rst = 1'b1;
    // Requests held during reset must not be granted.
    set_host(0, 1'b1, 32'h0010_0004, 1'b0, 32'h0);
    set_host(1, 1'b1, 32'h0010_0004, 1'b0, 32'h0);
    repeat (2) @(posedge clk);
    #1;
    chk("rst_gnt", host_gnt, 2'b00);
    chk("rst_dev_req", device_req, 3'b000);
    chk("rst_rvalid", host_rvalid, 2'b00);

    next_cycle();
    rst = 1'b0;
    set_host(0, 1'b0, 32'h0, 1'b0, 32'h0);
    set_host(1, 1'b0, 32'h0, 1'b0, 32'h0);

    // 1: host0 read of RAM.
    next_cycle();
    set_host(0, 1'b1, 32'h0010_0004, 1'b0, 32'h0);
    #1;
    chk("t1_gnt", host_gnt, 2'b01);
    chk("t1_dev_req", device_req, 3'b001);
    push_exp(0, 32'hDEAD_BEEF, 1'b0);

    // 2: host0 write to device 1, back-to-back with response 1.
    next_cycle();
    set_host(0, 1'b1, 32'h0002_0000, 1'b1, 32'h0000_0041);
    #1;
    chk("t2_gnt", host_gnt, 2'b01);
    chk("t2_dev_req", device_req, 3'b010);
    chk("t2_we", device_we[1], 1'b1);
    chk("t2_wdata", device_wdata[1], 32'h0000_0041);
    chk("t2_addr", device_addr[1], 32'h0002_0000);
    chk("t2_be", device_be[1], 4'hF);
    push_exp(0, 32'h0000_1111, 1'b0);

    // 3: both hosts request; host0 wins, host1 follows next cycle.
    next_cycle();
    set_host(0, 1'b1, 32'h0003_0000, 1'b0, 32'h0);
    set_host(1, 1'b1, 32'h0010_0000, 1'b0, 32'h0);
    #1;
    chk("t3_gnt", host_gnt, 2'b01);
    chk("t3_dev_req", device_req, 3'b100);
    push_exp(0, 32'h2222_0000, 1'b0);
    next_cycle();
    set_host(0, 1'b0, 32'h0, 1'b0, 32'h0);
    #1;
    chk("t3b_gnt", host_gnt, 2'b10);
    chk("t3b_dev_req", device_req, 3'b001);
    push_exp(1, 32'hDEAD_BEEF, 1'b0);

    // 4: unmapped address from host1.
    next_cycle();
    set_host(1, 1'b1, 32'h0005_0000, 1'b0, 32'h0);
    #1;
    chk("t4_gnt", host_gnt, 2'b10);
    chk("t4_dev_req", device_req, 3'b000);
    push_exp(1, 32'h0, 1'b1);

    // 5: timer answers with err.
    next_cycle();
    timer_err = 1'b1;
    set_host(1, 1'b1, 32'h0003_0010, 1'b0, 32'h0);
    #1;
    chk("t5_gnt", host_gnt, 2'b10);
    chk("t5_dev_req", device_req, 3'b100);
    push_exp(1, 32'h2222_0000, 1'b1);

    // Idle: nothing asserted, rdata zero.
    next_cycle();
    timer_err = 1'b0;
    set_host(1, 1'b0, 32'h0, 1'b0, 32'h0);
    #1;
    chk("idle_gnt", host_gnt, 2'b00);
    chk("idle_dev_req", device_req, 3'b000);
    next_cycle();
    chk("idle_rvalid", host_rvalid, 2'b00);
    chk("idle_rdata0", host_rdata[0], 32'h0);
    chk("idle_rdata1", host_rdata[1], 32'h0);
    chk("sb_drained", sb_q.size(), 32'd0);

    // 6: reset while the RAM response is due; it must be dropped.
    set_host(0, 1'b1, 32'h0010_0004, 1'b0, 32'h0);
    #1;
    chk("t6_gnt", host_gnt, 2'b01);
    next_cycle();
    rst = 1'b1;
    #1;
    chk("t6_rst_gnt", host_gnt, 2'b00);
    chk("t6_rst_dev_req", device_req, 3'b000);
    chk("t6_rst_rvalid", host_rvalid, 2'b00);
    next_cycle();
    chk("t6_rst_rvalid2", host_rvalid, 2'b00);
    next_cycle();
    rst = 1'b0;
    set_host(0, 1'b0, 32'h0, 1'b0, 32'h0);
    #1;
    chk("t6_post_rvalid", host_rvalid, 2'b00);
    repeat (3) next_cycle();
    chk("t6_post_rvalid2", host_rvalid, 2'b00);
    chk("sb_final", sb_q.size(), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
